// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file.
// Holds the default geometry constants and the controller state encoding.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NREAD  = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One read port of the register file: zero-latency bypass mux.
// Ports:
//   run_i     - controller is in RUN (reads are forced to 0 otherwise)
//   rf_en_i   - global enable; write bypass only applies when set
//   we_i      - write enables of the two write ports
//   waddr0_i  - write address, port 0
//   waddr1_i  - write address, port 1
//   wdata0_i  - write data, port 0
//   wdata1_i  - write data, port 1
//   raddr_i   - read address
//   stored_i  - array contents at raddr_i
//   rdata_o   - read data (combinational)
module rf_read_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              run_i,
  input  logic              rf_en_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] stored_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic hit0_s;
  logic hit1_s;

  // A hit does not look at clr: the bypass shows the presented write even
  // in the cycle a clear request discards it.
  assign hit0_s = run_i & rf_en_i & we_i[0] & (waddr0_i == raddr_i);
  assign hit1_s = run_i & rf_en_i & we_i[1] & (waddr1_i == raddr_i);

  // Bypass priority: address 0, then port 1, then port 0, then storage.
  always_comb begin
    rdata_o = '0;
    if (!run_i) begin
      rdata_o = '0;
    end else if (raddr_i == '0) begin
      rdata_o = '0;
    end else if (hit1_s) begin
      rdata_o = wdata1_i;
    end else if (hit0_s) begin
      rdata_o = wdata0_i;
    end else begin
      rdata_o = stored_i;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: 2 write ports, NREAD read ports with bypass,
// entry 0 hardwired to zero, and a sequential clear engine that zeroes
// entries 1..DEPTH-1 after reset or on request.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   rf_en  - global enable for writes and clear requests
//   clr    - soft-clear request (honoured in RUN with rf_en)
//   we     - write enables, bit k for write port k
//   waddr  - write addresses, port 0 in the low slice
//   wdata  - write data, port 0 in the low slice
//   raddr  - read addresses, port 0 in the low slice
//   rdata  - read data, port 0 in the low slice
//   ready  - 1 in RUN, 0 while clearing
module rf_multiport
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NREAD  = RF_NREAD
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rf_en,
  input  logic                    clr,
  input  logic [1:0]              we,
  input  logic [2*ADDR_W-1:0]     waddr,
  input  logic [2*DATA_W-1:0]     wdata,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic                    ready
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clear_ptr_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run_s;
  logic              clr_req_s;
  logic              wr_ok_s;
  logic [ADDR_W-1:0] waddr0_s;
  logic [ADDR_W-1:0] waddr1_s;
  logic [DATA_W-1:0] wdata0_s;
  logic [DATA_W-1:0] wdata1_s;

  assign waddr0_s  = waddr[ADDR_W-1:0];
  assign waddr1_s  = waddr[2*ADDR_W-1:ADDR_W];
  assign wdata0_s  = wdata[DATA_W-1:0];
  assign wdata1_s  = wdata[2*DATA_W-1:DATA_W];

  assign run_s     = (state_q == RUN);
  assign clr_req_s = run_s & rf_en & clr;
  // Writes in the cycle of an accepted clear request are discarded.
  assign wr_ok_s   = run_s & rf_en & ~clr;

  assign ready     = ready_q;

  // Controller: clear sweep over entries 1..DEPTH-1, then RUN until clr.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= CLEAR;
      clear_ptr_q <= PTR_FIRST;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          // The pointer holds at the last entry rather than wrapping.
          if (clear_ptr_q == PTR_LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            clear_ptr_q <= clear_ptr_q + PTR_FIRST;
          end
        end
        RUN: begin
          if (clr_req_s) begin
            state_q     <= CLEAR;
            clear_ptr_q <= PTR_FIRST;
            ready_q     <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= CLEAR;
          clear_ptr_q <= PTR_FIRST;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  // Storage: zeroed by the clear sweep, written by the two ports in RUN.
  // Entry 0 is never written; the read ports return 0 for it.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clear_ptr_q] <= '0;
    end else if (wr_ok_s) begin
      if (we[0] && (waddr0_s != '0)) begin
        mem_q[waddr0_s] <= wdata0_s;
      end
      // Port 1 is written last so it wins on an address collision.
      if (we[1] && (waddr1_s != '0)) begin
        mem_q[waddr1_s] <= wdata1_s;
      end
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr_s;

    assign rd_addr_s = raddr[g*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .run_i    (run_s),
      .rf_en_i  (rf_en),
      .we_i     (we),
      .waddr0_i (waddr0_s),
      .waddr1_i (waddr1_s),
      .wdata0_i (wdata0_s),
      .wdata1_i (wdata1_s),
      .raddr_i  (rd_addr_s),
      .stored_i (mem_q[rd_addr_s]),
      .rdata_o  (rdata[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_rf_multiport.sv
module tb_rf_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int CLEAR_CYCLES = 31;

  logic              clk;
  logic              resetn;
  logic              rf_en;
  logic              clr;
  logic [1:0]        we;
  logic [2*AW-1:0]   waddr;
  logic [2*DW-1:0]   wdata;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic              ready;

  int total;
  int bad;

  rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
    .clk    (clk),
    .resetn (resetn),
    .rf_en  (rf_en),
    .clr    (clr),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr  (raddr),
    .rdata  (rdata),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_left = clear cycles still to go; 0 means the file is usable.
  int          m_left;
  logic [31:0] m_mem [32];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= CLEAR_CYCLES;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        for (int i = 0; i < 32; i++) m_mem[i] <= 32'd0;
      end
    end else if (rf_en) begin
      if (clr) begin
        m_left <= CLEAR_CYCLES;
      end else begin
        if (we[0] && waddr[4:0] != 5'd0) m_mem[waddr[4:0]] <= wdata[31:0];
        if (we[1] && waddr[9:5] != 5'd0) m_mem[waddr[9:5]] <= wdata[63:32];
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (m_left != 0)                                  return 32'd0;
    if (ra == 5'd0)                                   return 32'd0;
    if (rf_en && we[1] && waddr[9:5] == ra)           return wdata[63:32];
    if (rf_en && we[0] && waddr[4:0] == ra)           return wdata[31:0];
    return m_mem[ra];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    check("ready", {31'd0, ready}, {31'd0, (m_left == 0)});
    for (int p = 0; p < NR; p++) begin
      check("rdata_model", rdata[p*DW +: DW], exp_rd(raddr[p*AW +: AW]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic c, input logic [1:0] w,
                       input logic [4:0] wa1, input logic [4:0] wa0,
                       input logic [31:0] wd1, input logic [31:0] wd0,
                       input logic [4:0] ra1, input logic [4:0] ra0);
    rf_en = en;
    clr   = c;
    we    = w;
    waddr = {wa1, wa0};
    wdata = {wd1, wd0};
    raddr = {ra1, ra0};
  endtask

  task automatic idle(input logic [4:0] ra1, input logic [4:0] ra0);
    drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, ra1, ra0);
  endtask

  // Counts rising edges until ready is seen high (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    #3;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rdata0", rdata[31:0], 32'd0);
    #20;
    rf_en  = 1'b1;
    resetn = 1'b1;

    // Initial clear takes 31 edges.
    wait_ready(n);
    check("init_clear_cycles", n, 32'd31);

    // Every address reads zero after the clear.
    for (int a = 0; a < 32; a++) begin
      idle(5'(31 - a), 5'(a));
      mid();
      check("sweep_zero0", rdata[31:0], 32'd0);
      check("sweep_zero1", rdata[63:32], 32'd0);
      next_cycle();
    end

    // Port 0 write with same-cycle bypass, then stored value.
    drive(1'b1, 1'b0, 2'b01, 5'd0, 5'd5, 32'd0, 32'hDEADBEEF, 5'd5, 5'd5);
    mid();
    check("bypass_p0", rdata[31:0], 32'hDEADBEEF);
    next_cycle();
    idle(5'd0, 5'd5);
    mid();
    check("stored_p0", rdata[31:0], 32'hDEADBEEF);
    next_cycle();

    // Both ports write addr 7: port 1 wins.
    drive(1'b1, 1'b0, 2'b11, 5'd7, 5'd7, 32'h22, 32'h11, 5'd7, 5'd7);
    mid();
    check("collide_bypass", rdata[31:0], 32'h22);
    next_cycle();
    idle(5'd7, 5'd5);
    mid();
    check("collide_stored", rdata[63:32], 32'h22);
    check("addr5_kept", rdata[31:0], 32'hDEADBEEF);
    next_cycle();

    // Writes to entry 0 are dropped and never bypassed.
    drive(1'b1, 1'b0, 2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0);
    mid();
    check("zero_bypass", rdata[31:0], 32'd0);
    next_cycle();
    idle(5'd0, 5'd0);
    mid();
    check("zero_stored", rdata[63:32], 32'd0);
    next_cycle();

    // Distinct addresses on each port, cross-read.
    drive(1'b1, 1'b0, 2'b11, 5'd4, 5'd3, 32'h5A, 32'hA5, 5'd3, 5'd4);
    mid();
    check("cross_rd0", rdata[31:0], 32'h5A);
    check("cross_rd1", rdata[63:32], 32'hA5);
    next_cycle();

    // rf_en=0: no bypass, no write, clr ignored.
    drive(1'b0, 1'b1, 2'b11, 5'd5, 5'd5, 32'h1234, 32'h1234, 5'd3, 5'd5);
    mid();
    check("disabled_nobypass", rdata[31:0], 32'hDEADBEEF);
    next_cycle();
    idle(5'd3, 5'd5);
    mid();
    check("disabled_ready", {31'd0, ready}, 32'd1);
    check("disabled_nowrite", rdata[31:0], 32'hDEADBEEF);
    check("addr3", rdata[63:32], 32'hA5);
    next_cycle();

    // Write addr 9 then clear: 31 cycles not ready, then addr 9 is 0.
    drive(1'b1, 1'b0, 2'b01, 5'd0, 5'd9, 32'd0, 32'h55, 5'd0, 5'd9);
    next_cycle();
    drive(1'b1, 1'b1, 2'b10, 5'd10, 5'd0, 32'h77, 32'd0, 5'd10, 5'd9);
    mid();
    check("pre_clr_addr9", rdata[31:0], 32'h55);
    next_cycle();
    idle(5'd10, 5'd9);
    check("clr_ready_low", {31'd0, ready}, 32'd0);
    wait_ready(n);
    check("clr_cycles", n, 32'd31);
    mid();
    check("clr_addr9", rdata[31:0], 32'd0);
    check("clr_addr10", rdata[63:32], 32'd0);
    next_cycle();

    // Asynchronous reset in RUN forces outputs to 0 immediately.
    drive(1'b1, 1'b0, 2'b01, 5'd0, 5'd12, 32'd0, 32'h0000CAFE, 5'd0, 5'd12);
    next_cycle();
    idle(5'd0, 5'd12);
    mid();
    check("cafe_stored", rdata[31:0], 32'h0000CAFE);
    next_cycle();
    #2 resetn = 1'b0;
    #1;
    check("run_rst_ready", {31'd0, ready}, 32'd0);
    check("run_rst_rdata", rdata[31:0], 32'd0);
    #2 resetn = 1'b1;

    // Reset again at CLEAR cycle 10: clear restarts from the beginning.
    for (int i = 0; i < 10; i++) next_cycle();
    #2 resetn = 1'b0;
    #1;
    check("clr_rst_ready", {31'd0, ready}, 32'd0);
    #2 resetn = 1'b1;
    wait_ready(n);
    check("restart_cycles", n, 32'd31);
    mid();
    check("restart_addr12", rdata[31:0], 32'd0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
